// File: rtl/i2c_lcd_rx.sv
// Write-only I2C slave modelling a PCF8574-style LCD backpack port expander.
// Oversamples scl/sda on ck, ACKs its address and latches each data byte onto port_q.
module i2c_lcd_rx #(
    parameter logic [6:0] ADDR = 7'h27
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] port_q,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_hit,
    output logic [7:0] byte_cnt,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    state_t     state_q, state_d;

    logic       scl_m_q, scl_s_q, scl_p_q;
    logic       sda_m_q, sda_s_q, sda_p_q;

    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       byte_done_q, byte_done_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] port_val_q, port_val_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       addr_hit_q, addr_hit_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic       busy_q, busy_d;

    logic       scl_rise, scl_fall, start_ev, stop_ev, addr_match;

    // START/STOP need scl high on both samples, so a simultaneous scl+sda change is neither.
    always_comb begin
        scl_rise   = !scl_p_q && scl_s_q;
        scl_fall   = scl_p_q && !scl_s_q;
        start_ev   = scl_p_q && scl_s_q && sda_p_q && !sda_s_q;
        stop_ev    = scl_p_q && scl_s_q && !sda_p_q && sda_s_q;
        addr_match = (shreg_q[7:1] == ADDR) && !shreg_q[0];
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            state_q     <= S_IDLE;
            scl_m_q     <= 1'b1;
            scl_s_q     <= 1'b1;
            scl_p_q     <= 1'b1;
            sda_m_q     <= 1'b1;
            sda_s_q     <= 1'b1;
            sda_p_q     <= 1'b1;
            shreg_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            port_val_q  <= 8'hFF;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            addr_hit_q  <= 1'b0;
            byte_cnt_q  <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scl_m_q     <= scl;
            scl_s_q     <= scl_m_q;
            scl_p_q     <= scl_s_q;
            sda_m_q     <= sda_in;
            sda_s_q     <= sda_m_q;
            sda_p_q     <= sda_s_q;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
            sda_oe_q    <= sda_oe_d;
            port_val_q  <= port_val_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            addr_hit_q  <= addr_hit_d;
            byte_cnt_q  <= byte_cnt_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop_ev) begin
            state_d = S_IDLE;
        end else if (start_ev) begin
            state_d = S_ADDR;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_fall && byte_done_q)
                        state_d = addr_match ? S_ADDR_ACK : S_IGNORE;
                end
                S_ADDR_ACK: if (scl_fall) state_d = S_DATA;
                S_DATA:     if (scl_fall && byte_done_q) state_d = S_DATA_ACK;
                S_DATA_ACK: if (scl_fall) state_d = S_DATA;
                default:    state_d = state_q;
            endcase
        end
    end

    // byte_done marks that the 8th bit has been shifted; the scl_fall after it acts on the byte.
    always_comb begin
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = byte_done_q;
        sda_oe_d    = sda_oe_q;
        port_val_d  = port_val_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        addr_hit_d  = addr_hit_q;
        byte_cnt_d  = byte_cnt_q;
        busy_d      = busy_q;
        if (stop_ev) begin
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            addr_hit_d = 1'b0;
        end else if (start_ev) begin
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            byte_cnt_d  = 8'h00;
            addr_hit_d  = 1'b0;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b1;
        end else begin
            case (state_q)
                S_ADDR, S_DATA: begin
                    if (scl_rise) begin
                        shreg_d   = {shreg_q[6:0], sda_s_q};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7)
                            byte_done_d = 1'b1;
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        if (state_q == S_ADDR) begin
                            sda_oe_d = addr_match;
                        end else begin
                            sda_oe_d   = 1'b1;
                            rx_data_d  = shreg_q;
                            port_val_d = shreg_q;
                            rx_valid_d = 1'b1;
                            byte_cnt_d = (byte_cnt_q == 8'hFF) ? 8'hFF : byte_cnt_q + 8'd1;
                        end
                    end
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d    = 1'b0;
                        bit_cnt_d   = 3'd0;
                        byte_done_d = 1'b0;
                        if (state_q == S_ADDR_ACK)
                            addr_hit_d = 1'b1;
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    assign sda_oe   = sda_oe_q;
    assign port_q   = port_val_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign addr_hit = addr_hit_q;
    assign byte_cnt = byte_cnt_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_lcd_rx.sv
// Directed bench for i2c_lcd_rx: a bit-banged I2C master on a wired-AND sda line.
module tb_i2c_lcd_rx;

    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] port_q;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_hit;
    logic [7:0] byte_cnt;
    logic       busy;

    int         compare_count = 0;
    int         mismatch_count = 0;
    int         pulse_count = 0;
    int         oe_cycles = 0;
    logic       clear_mon = 1'b0;
    logic [7:0] rx_log [0:7];

    logic       ack, oe, busy_early;

    assign sda_in = sda_m & ~sda_oe;

    i2c_lcd_rx #(.ADDR(7'h27)) dut (
        .ck       (ck),
        .reset    (reset),
        .scl      (scl_m),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .port_q   (port_q),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .addr_hit (addr_hit),
        .byte_cnt (byte_cnt),
        .busy     (busy)
    );

    always #5 ck = ~ck;

    // Logs every rx_valid cycle so stretched or missing pulses show up in the count.
    always @(negedge ck) begin
        if (clear_mon) begin
            pulse_count = 0;
            oe_cycles   = 0;
        end else begin
            if (rx_valid) begin
                if (pulse_count < 8) rx_log[pulse_count] = rx_data;
                pulse_count++;
            end
            if (sda_oe) oe_cycles++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic wait_ck(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic clear_monitor();
        clear_mon = 1'b1;
        wait_ck(1);
        clear_mon = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_ck(2);
        reset = 1'b0;
        wait_ck(4);
        clear_monitor();
    endtask

    task automatic bus_start();
        if (!scl_m) begin
            wait_ck(3);
            sda_m = 1'b1;
            wait_ck(7);
            scl_m = 1'b1;
            wait_ck(10);
        end else begin
            sda_m = 1'b1;
            wait_ck(5);
        end
        sda_m = 1'b0;
        wait_ck(10);
        scl_m = 1'b0;
    endtask

    task automatic bus_stop(output logic busy_mid);
        wait_ck(3);
        sda_m = 1'b0;
        wait_ck(7);
        scl_m = 1'b1;
        wait_ck(10);
        sda_m = 1'b1;
        wait_ck(2);
        busy_mid = busy;
        wait_ck(8);
    endtask

    task automatic send_bit(input logic b);
        wait_ck(3);
        sda_m = b;
        wait_ck(7);
        scl_m = 1'b1;
        wait_ck(10);
        scl_m = 1'b0;
    endtask

    task automatic ack_bit(output logic ack_seen, output logic oe_seen);
        sda_m = 1'b1;
        wait_ck(10);
        scl_m = 1'b1;
        wait_ck(5);
        ack_seen = ~sda_in;
        oe_seen  = sda_oe;
        wait_ck(5);
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack_seen, output logic oe_seen);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_bit(ack_seen, oe_seen);
    endtask

    initial begin
        do_reset();
        reset = 1'b1;
        wait_ck(1);
        reset = 1'b0;
        checkOutput("rst sda_oe", sda_oe, 1'b0);
        checkOutput("rst port_q", port_q, 8'hFF);
        checkOutput("rst rx_data", rx_data, 8'h00);
        checkOutput("rst rx_valid", rx_valid, 1'b0);
        checkOutput("rst addr_hit", addr_hit, 1'b0);
        checkOutput("rst byte_cnt", byte_cnt, 8'h00);
        checkOutput("rst busy", busy, 1'b0);

        // Wrong address 0x3F: no ACK, no data, port untouched.
        do_reset();
        bus_start();
        checkOutput("t2 busy", busy, 1'b1);
        write_byte(8'h7E, ack, oe);
        checkOutput("t2 addr ack", ack, 1'b0);
        write_byte(8'h55, ack, oe);
        checkOutput("t2 data ack", ack, 1'b0);
        bus_stop(busy_early);
        checkOutput("t2 oe cycles", oe_cycles, 0);
        checkOutput("t2 pulses", pulse_count, 0);
        checkOutput("t2 port_q", port_q, 8'hFF);

        // Single byte 0x4C to 0x27.
        do_reset();
        bus_start();
        write_byte(8'h4E, ack, oe);
        checkOutput("t1 addr ack", ack, 1'b1);
        checkOutput("t1 addr oe", oe, 1'b1);
        checkOutput("t1 addr_hit", addr_hit, 1'b0);
        wait_ck(1);
        write_byte(8'h4C, ack, oe);
        checkOutput("t1 data ack", ack, 1'b1);
        checkOutput("t1 data oe", oe, 1'b1);
        checkOutput("t1 addr_hit", addr_hit, 1'b1);
        checkOutput("t1 pulses", pulse_count, 1);
        checkOutput("t1 rx_data", rx_log[0], 8'h4C);
        checkOutput("t1 port_q", port_q, 8'h4C);
        checkOutput("t1 byte_cnt", byte_cnt, 8'd1);
        bus_stop(busy_early);
        checkOutput("t1 busy 2ck after stop", busy_early, 1'b1);
        checkOutput("t1 busy after stop", busy, 1'b0);
        checkOutput("t1 addr_hit after stop", addr_hit, 1'b0);
        checkOutput("t1 port_q hold", port_q, 8'h4C);
        checkOutput("t1 byte_cnt hold", byte_cnt, 8'd1);
        checkOutput("t1 sda_oe after stop", sda_oe, 1'b0);

        // Read request to 0x27: NACK, then everything ignored.
        do_reset();
        bus_start();
        write_byte(8'h4F, ack, oe);
        checkOutput("t3 addr ack", ack, 1'b0);
        write_byte(8'h12, ack, oe);
        checkOutput("t3 data ack", ack, 1'b0);
        checkOutput("t3 busy", busy, 1'b1);
        checkOutput("t3 addr_hit", addr_hit, 1'b0);
        bus_stop(busy_early);
        checkOutput("t3 pulses", pulse_count, 0);
        checkOutput("t3 oe cycles", oe_cycles, 0);

        // Three-byte LCD nibble sequence.
        do_reset();
        bus_start();
        write_byte(8'h4E, ack, oe);
        write_byte(8'h08, ack, oe);
        checkOutput("t4 ack0", ack, 1'b1);
        write_byte(8'h0C, ack, oe);
        checkOutput("t4 ack1", ack, 1'b1);
        write_byte(8'h08, ack, oe);
        checkOutput("t4 ack2", ack, 1'b1);
        bus_stop(busy_early);
        checkOutput("t4 pulses", pulse_count, 3);
        checkOutput("t4 rx0", rx_log[0], 8'h08);
        checkOutput("t4 rx1", rx_log[1], 8'h0C);
        checkOutput("t4 rx2", rx_log[2], 8'h08);
        checkOutput("t4 byte_cnt", byte_cnt, 8'd3);
        checkOutput("t4 port_q", port_q, 8'h08);

        // Repeated START after 4 data bits discards the partial byte.
        do_reset();
        bus_start();
        write_byte(8'h4E, ack, oe);
        write_byte(8'h11, ack, oe);
        checkOutput("t5 byte_cnt first", byte_cnt, 8'd1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        bus_start();
        wait_ck(5);
        checkOutput("t5 byte_cnt cleared", byte_cnt, 8'd0);
        checkOutput("t5 pulses before", pulse_count, 1);
        write_byte(8'h4E, ack, oe);
        checkOutput("t5 addr ack", ack, 1'b1);
        write_byte(8'hA5, ack, oe);
        bus_stop(busy_early);
        checkOutput("t5 pulses", pulse_count, 2);
        checkOutput("t5 rx", rx_log[1], 8'hA5);
        checkOutput("t5 byte_cnt", byte_cnt, 8'd1);
        checkOutput("t5 port_q", port_q, 8'hA5);

        // Reset pulse while the slave is ACKing a data byte.
        do_reset();
        bus_start();
        write_byte(8'h4E, ack, oe);
        for (int i = 7; i >= 0; i--) send_bit(8'h3C >> i);
        for (int i = 0; i < 8 && !sda_oe; i++) wait_ck(1);
        checkOutput("t6 oe before reset", sda_oe, 1'b1);
        checkOutput("t6 port_q before reset", port_q, 8'h3C);
        reset = 1'b1;
        wait_ck(1);
        reset = 1'b0;
        checkOutput("t6 oe after reset", sda_oe, 1'b0);
        checkOutput("t6 port_q after reset", port_q, 8'hFF);
        clear_monitor();
        sda_m = 1'b1;
        wait_ck(3);
        scl_m = 1'b1;
        wait_ck(10);
        scl_m = 1'b0;
        write_byte(8'h77, ack, oe);
        checkOutput("t6 ignored ack", ack, 1'b0);
        checkOutput("t6 busy", busy, 1'b0);
        checkOutput("t6 pulses", pulse_count, 0);
        checkOutput("t6 oe cycles", oe_cycles, 0);
        checkOutput("t6 port_q", port_q, 8'hFF);
        bus_stop(busy_early);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
